// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA unified-memory arbiter.
// Contents: FSM state enum, owner encodings, counter-width helper.
// Imported by mem_arbiter and mem_arb_wait_ctr.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Bits needed to hold 0..maxval, never less than one bit.
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Loadable down-counter that paces the wait states of one memory access.
// Latency: load/decrement take effect on the next clock; zero is combinational from the count.
// Backpressure: none; dec is ignored once the count has reached zero.
//
// Ports:
//   clk, reset (async, active-low)
//   load / load_val : reload the count (load wins over dec)
//   dec             : decrement by one when non-zero
//   zero            : count is zero
module mem_arb_wait_ctr
  import mem_arb_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA accesses onto one byte-wide memory with per-requester ack pulses.
// Latency: req sampled at edge E, mem_en for WAIT_STATES+1 cycles, ack one cycle later (WAIT_STATES+2).
// Backpressure: requesters hold req/fields until their ack; cpu_stall = cpu_req & ~cpu_ack.
//
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata, cpu_ack, cpu_stall
//   dma_req/dma_we/dma_addr/dma_wdata/dma_last -> dma_rdata, dma_ack
//   mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
//   owner : 0 = CPU, 1 = DMA (current or most recent grant)
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate unlocked ties;
// otherwise the CPU always wins an unlocked tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW            = 8,
  parameter int DW            = 8,
  parameter int WAIT_STATES   = 1,
  parameter int DMA_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_last,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  localparam int WCW = cnt_width(WAIT_STATES);
  localparam int BCW = cnt_width(DMA_BURST_MAX);
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_STATES);
  localparam logic [BCW-1:0] BURST_LIM = BCW'(DMA_BURST_MAX);

  arb_state_t     state;
  logic           lock;
  logic [BCW-1:0] bcnt;

  logic           any_req;
  logic           win;
  logic [BCW-1:0] bcnt_inc;
  logic           burst_end;
  logic           ctr_load;
  logic           ctr_dec;
  logic           ctr_zero;

  assign any_req   = cpu_req | dma_req;
  assign ctr_load  = (state == IDLE) & any_req;
  assign ctr_dec   = (state == ACCESS);
  assign cpu_stall = cpu_req & ~cpu_ack;

  // Beat count including the beat being granted now; a fresh burst starts at 1.
  assign bcnt_inc  = lock ? (bcnt + 1'b1) : BCW'(1);
  assign burst_end = dma_last | (bcnt_inc == BURST_LIM);

  // Winner selection for the IDLE edge. An active burst lock keeps the DMA
  // on the bus as long as it keeps requesting.
  always_comb begin
    win = OWN_CPU;
    if (lock && dma_req) begin
      win = OWN_DMA;
    end else if (cpu_req && dma_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win = ~owner;
`else
      win = OWN_CPU;
`endif
    end else if (dma_req) begin
      win = OWN_DMA;
    end
  end

  mem_arb_wait_ctr #(
    .W (WCW)
  ) u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (WAIT_LOAD),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      owner     <= OWN_DMA;   // makes the CPU the first alternating-tie winner
      lock      <= 1'b0;
      bcnt      <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          // A locked DMA that lets go of req in IDLE gives up its burst.
          if (lock && !dma_req) begin
            lock <= 1'b0;
            bcnt <= '0;
          end
          if (any_req) begin
            state  <= ACCESS;
            owner  <= win;
            mem_en <= 1'b1;
            if (win == OWN_DMA) begin
              mem_we    <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
              if (burst_end) begin
                lock <= 1'b0;
                bcnt <= '0;
              end else begin
                lock <= 1'b1;
                bcnt <= bcnt_inc;
              end
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end
        ACCESS: begin
          if (ctr_zero) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            // mem_we still holds the latched direction at this edge.
            if (owner == OWN_DMA) begin
              dma_ack <= 1'b1;
              if (!mem_we) dma_rdata <= mem_rdata;
            end else begin
              cpu_ack <= 1'b1;
              if (!mem_we) cpu_rdata <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: WAIT_STATES=1 instance with CPU/DMA agents and a grant/ack scoreboard,
// plus a WAIT_STATES=0 instance used for back-to-back throughput.
// Expected grant order follows the MEM_ARB_ROUND_ROBIN_EN build setting.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n;
  logic       cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dma_req, dma_we, dma_last, dma_ack;
  logic [7:0] dma_addr, dma_wdata, dma_rdata;
  logic       mem_en, mem_we, owner;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  logic       z_cpu_req, z_cpu_we, z_cpu_ack, z_cpu_stall;
  logic [7:0] z_cpu_addr, z_cpu_wdata, z_cpu_rdata;
  logic       z_dma_req, z_dma_we, z_dma_last, z_dma_ack;
  logic [7:0] z_dma_addr, z_dma_wdata, z_dma_rdata;
  logic       z_mem_en, z_mem_we, z_owner;
  logic [7:0] z_mem_addr, z_mem_wdata, z_mem_rdata;
  assign z_mem_rdata = ~z_mem_addr;

  mem_arbiter #(.AW(8), .DW(8), .WAIT_STATES(1), .DMA_BURST_MAX(4)) u_dut (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  mem_arbiter #(.AW(8), .DW(8), .WAIT_STATES(0), .DMA_BURST_MAX(4)) u_dut0 (
    .clk(clk), .reset(rst_n),
    .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
    .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack), .cpu_stall(z_cpu_stall),
    .dma_req(z_dma_req), .dma_we(z_dma_we), .dma_addr(z_dma_addr), .dma_wdata(z_dma_wdata),
    .dma_last(z_dma_last), .dma_rdata(z_dma_rdata), .dma_ack(z_dma_ack),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .owner(z_owner)
  );

  typedef struct packed {logic we; logic last; logic [7:0] addr; logic [7:0] wdata;} cmd_t;
  typedef struct packed {logic own; logic we; logic [7:0] addr; logic [7:0] wdata; logic [7:0] rdata;} exp_t;

  cmd_t cpu_q[$];
  cmd_t dma_q[$];
  exp_t exp_grant[$];
  exp_t exp_cpu[$];
  exp_t exp_dma[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cpu_issue = 0;

  function automatic logic [7:0] pat(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h3C);
  endfunction

  function automatic cmd_t cm(input logic we, input logic last, input logic [7:0] a, input logic [7:0] wd);
    cmd_t c;
    c.we = we; c.last = last; c.addr = a; c.wdata = wd;
    return c;
  endfunction

  function automatic exp_t mk(input logic own, input logic we, input logic [7:0] a, input logic [7:0] wd);
    exp_t e;
    e.own = own; e.we = we; e.addr = a; e.wdata = wd; e.rdata = pat(a);
    return e;
  endfunction

  task automatic mem_model();
    for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    end
  endtask

  task automatic cpu_agent();
    cmd_t c;
    forever begin
      @(negedge clk);
      if (cpu_req && cpu_ack) cpu_req = 1'b0;
      if (!cpu_req && cpu_q.size() > 0) begin
        c = cpu_q.pop_front();
        cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.wdata;
        cpu_req = 1'b1; cpu_issue = cyc;
      end
    end
  endtask

  task automatic dma_agent();
    cmd_t c;
    forever begin
      @(negedge clk);
      if (dma_req && dma_ack) dma_req = 1'b0;
      if (!dma_req && dma_q.size() > 0) begin
        c = dma_q.pop_front();
        dma_we = c.we; dma_last = c.last; dma_addr = c.addr; dma_wdata = c.wdata;
        dma_req = 1'b1;
      end
    end
  endtask

  // Scoreboard consumer: each new mem_en pulse pops the expected grant, each ack pops the expected completion.
  task automatic monitor();
    exp_t e;
    logic en_q = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_en && !en_q) begin
        n_cmp++;
        if (exp_grant.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected: got own=%0d addr=%h, required no grant", owner, mem_addr);
        end else begin
          e = exp_grant.pop_front();
          if ({owner, mem_we, mem_addr, mem_wdata} !== {e.own, e.we, e.addr, e.wdata}) begin
            n_fail++;
            $display("FAIL grant_order: got own=%0d we=%0d addr=%h wd=%h, required own=%0d we=%0d addr=%h wd=%h",
                     owner, mem_we, mem_addr, mem_wdata, e.own, e.we, e.addr, e.wdata);
          end
        end
      end
      en_q = mem_en;
      if (cpu_ack || dma_ack) begin
        n_cmp++;
        if (cpu_ack && dma_ack) begin
          n_fail++;
          $display("FAIL ack_exclusive: got cpu_ack=1 dma_ack=1, required at most one");
        end
      end
      if (cpu_ack) begin
        n_cmp++;
        if (exp_cpu.size() == 0) begin
          n_fail++;
          $display("FAIL cpu_ack_unexpected: got ack, required none");
        end else begin
          e = exp_cpu.pop_front();
          if (!e.we && cpu_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL cpu_rdata: got %h, required %h (addr %h)", cpu_rdata, e.rdata, e.addr);
          end
        end
      end
      if (dma_ack) begin
        n_cmp++;
        if (exp_dma.size() == 0) begin
          n_fail++;
          $display("FAIL dma_ack_unexpected: got ack, required none");
        end else begin
          e = exp_dma.pop_front();
          if (!e.we && dma_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL dma_rdata: got %h, required %h (addr %h)", dma_rdata, e.rdata, e.addr);
          end
        end
      end
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_grant.size() == 0 && exp_cpu.size() == 0 && exp_dma.size() == 0 &&
          cpu_q.size() == 0 && dma_q.size() == 0 && !cpu_req && !dma_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 18'h0) begin
      n_fail++; $display("FAIL reset_mem: got en=%0d we=%0d addr=%h wd=%h, required all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({cpu_ack, dma_ack, cpu_rdata, dma_rdata} !== 18'h0) begin
      n_fail++; $display("FAIL reset_acks: got acks=%b rdata=%h/%h, required 0", {cpu_ack, dma_ack}, cpu_rdata, dma_rdata);
    end
    n_cmp++;
    if (owner !== 1'b1 || z_owner !== 1'b1) begin
      n_fail++; $display("FAIL reset_owner: got %0d/%0d, required 1", owner, z_owner);
    end
    n_cmp++;
    if ({cpu_stall, z_mem_en, z_mem_we, z_mem_wdata, z_dma_ack, z_dma_rdata} !== 20'h0) begin
      n_fail++; $display("FAIL reset_misc: got stall=%0d z_en=%0d z_we=%0d, required 0", cpu_stall, z_mem_en, z_mem_we);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mem_en !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req: got mem_en=%0d, required 0", mem_en);
    end
  endtask

  task automatic test_basic_read();
    int  en_cycles = 0;
    int  lat = -1;
    bit  got = 1'b0;
    bit  ok;
    logic stall_mid = 1'b0;
    logic stall_ack = 1'b1;
    exp_grant.push_back(mk(1'b0, 1'b0, 8'h10, 8'h00));
    exp_cpu.push_back(mk(1'b0, 1'b0, 8'h10, 8'h00));
    @(posedge clk);
    cpu_q.push_back(cm(1'b0, 1'b0, 8'h10, 8'h00));
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_en) en_cycles++;
      if (mem_en && !cpu_ack) stall_mid = cpu_stall;
      if (cpu_ack) begin
        got = 1'b1; lat = cyc - cpu_issue; stall_ack = cpu_stall;
      end
    end
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d, required 3", lat); end
    n_cmp++;
    if (en_cycles !== 2) begin n_fail++; $display("FAIL read_mem_en_cycles: got %0d, required 2", en_cycles); end
    n_cmp++;
    if (stall_mid !== 1'b1 || stall_ack !== 1'b0) begin
      n_fail++; $display("FAIL read_stall: got mid=%0d ack=%0d, required 1/0", stall_mid, stall_ack);
    end
    drain(ok);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!ok || cpu_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL read_hold: got drained=%0d rdata=%h, required 1/a5", ok, cpu_rdata);
    end
  endtask

  task automatic test_tie();
    bit ok;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_grant.push_back(mk(1'b0, 1'b0, 8'h20, 8'h00));
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_grant.push_back(mk(1'b1, 1'b0, 8'h30, 8'h00));
    exp_grant.push_back(mk(1'b0, 1'b0, 8'h21, 8'h00));
`else
    exp_grant.push_back(mk(1'b0, 1'b0, 8'h21, 8'h00));
    exp_grant.push_back(mk(1'b1, 1'b0, 8'h30, 8'h00));
`endif
    exp_cpu.push_back(mk(1'b0, 1'b0, 8'h20, 8'h00));
    exp_cpu.push_back(mk(1'b0, 1'b0, 8'h21, 8'h00));
    exp_dma.push_back(mk(1'b1, 1'b0, 8'h30, 8'h00));
    @(posedge clk);
    cpu_q.push_back(cm(1'b0, 1'b0, 8'h20, 8'h00));
    cpu_q.push_back(cm(1'b0, 1'b0, 8'h21, 8'h00));
    dma_q.push_back(cm(1'b0, 1'b1, 8'h30, 8'h00));
    drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL tie_drain: got pending grants=%0d, required 0", exp_grant.size()); end
  endtask

  task automatic test_dma_burst();
    bit ok;
    for (int i = 0; i < 4; i++) exp_grant.push_back(mk(1'b1, 1'b1, 8'(8'h80 + i), 8'(8'hC0 + i)));
    exp_grant.push_back(mk(1'b0, 1'b0, 8'h40, 8'h00));
    for (int i = 4; i < 6; i++) exp_grant.push_back(mk(1'b1, 1'b1, 8'(8'h80 + i), 8'(8'hC0 + i)));
    for (int i = 0; i < 6; i++) exp_dma.push_back(mk(1'b1, 1'b1, 8'(8'h80 + i), 8'(8'hC0 + i)));
    exp_cpu.push_back(mk(1'b0, 1'b0, 8'h40, 8'h00));
    @(posedge clk);
    for (int i = 0; i < 6; i++) dma_q.push_back(cm(1'b1, (i == 5), 8'(8'h80 + i), 8'(8'hC0 + i)));
    for (int i = 0; i < 20 && !mem_en; i++) @(negedge clk);
    @(posedge clk);
    cpu_q.push_back(cm(1'b0, 1'b0, 8'h40, 8'h00));
    drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL burst_drain: got pending grants=%0d, required 0", exp_grant.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (mem[8'(8'h80 + i)] !== 8'(8'hC0 + i)) begin
        n_fail++; $display("FAIL burst_write[%0d]: got %h, required %h", i, mem[8'(8'h80 + i)], 8'(8'hC0 + i));
      end
    end
  endtask

  task automatic test_dma_last_early();
    bit ok;
    exp_grant.push_back(mk(1'b1, 1'b0, 8'h50, 8'h00));
    exp_grant.push_back(mk(1'b1, 1'b0, 8'h51, 8'h00));
    exp_grant.push_back(mk(1'b0, 1'b0, 8'h41, 8'h00));
    exp_grant.push_back(mk(1'b1, 1'b0, 8'h52, 8'h00));
    exp_dma.push_back(mk(1'b1, 1'b0, 8'h50, 8'h00));
    exp_dma.push_back(mk(1'b1, 1'b0, 8'h51, 8'h00));
    exp_dma.push_back(mk(1'b1, 1'b0, 8'h52, 8'h00));
    exp_cpu.push_back(mk(1'b0, 1'b0, 8'h41, 8'h00));
    @(posedge clk);
    dma_q.push_back(cm(1'b0, 1'b0, 8'h50, 8'h00));
    dma_q.push_back(cm(1'b0, 1'b1, 8'h51, 8'h00));
    dma_q.push_back(cm(1'b0, 1'b1, 8'h52, 8'h00));
    for (int i = 0; i < 20 && !mem_en; i++) @(negedge clk);
    @(posedge clk);
    cpu_q.push_back(cm(1'b0, 1'b0, 8'h41, 8'h00));
    drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL last_drain: got pending grants=%0d, required 0", exp_grant.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_grant.push_back(mk(1'b0, 1'b1, 8'h61, 8'h77));
    exp_grant.push_back(mk(1'b0, 1'b1, 8'h61, 8'h77));
    exp_cpu.push_back(mk(1'b0, 1'b1, 8'h61, 8'h77));
    @(posedge clk);
    cpu_q.push_back(cm(1'b1, 1'b0, 8'h61, 8'h77));
    for (int i = 0; i < 20 && !mem_en; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre: got en=%0d we=%0d, required 1/1", mem_en, mem_we);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL abort_drop: got en=%0d we=%0d, required 0/0", mem_en, mem_we);
    end
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack: got %0d, required 0", cpu_ack); end
    end
    rst_n = 1'b1;
    drain(ok);
    n_cmp++;
    if (!ok || mem[8'h61] !== 8'h77 || owner !== 1'b0) begin
      n_fail++; $display("FAIL abort_reserve: got drained=%0d mem=%h owner=%0d, required 1/77/0", ok, mem[8'h61], owner);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] addrs [4] = '{8'h01, 8'h22, 8'h93, 8'hF4};
    logic [7:0] zq[$];
    logic [7:0] e;
    int last_c;
    int n_acks = 0;
    int k = 1;
    @(negedge clk);
    z_cpu_we = 1'b0; z_cpu_addr = addrs[0]; z_cpu_req = 1'b1;
    zq.push_back(addrs[0]);
    last_c = cyc;
    for (int i = 0; i < 40 && n_acks < 4; i++) begin
      @(negedge clk);
      if (z_mem_en && zq.size() > 0) begin
        n_cmp++;
        if (z_mem_addr !== zq[0]) begin n_fail++; $display("FAIL b2b_addr: got %h, required %h", z_mem_addr, zq[0]); end
      end
      if (z_cpu_ack && zq.size() > 0) begin
        e = zq.pop_front();
        n_cmp++;
        if (z_cpu_rdata !== ~e) begin n_fail++; $display("FAIL b2b_rdata: got %h, required %h", z_cpu_rdata, ~e); end
        n_cmp++;
        if (cyc - last_c !== 2 || z_cpu_stall !== 1'b0) begin
          n_fail++; $display("FAIL b2b_spacing: got %0d cycles stall=%0d, required 2/0", cyc - last_c, z_cpu_stall);
        end
        last_c = cyc;
        n_acks++;
        if (k < 4) begin
          z_cpu_addr = addrs[k]; zq.push_back(addrs[k]); k++;
        end else begin
          z_cpu_req = 1'b0;
        end
      end
    end
    n_cmp++;
    if (n_acks !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d acks, required 4", n_acks); end
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_last = 1'b0; dma_addr = '0; dma_wdata = '0;
    z_cpu_req = 1'b0; z_cpu_we = 1'b0; z_cpu_addr = '0; z_cpu_wdata = '0;
    z_dma_req = 1'b0; z_dma_we = 1'b0; z_dma_last = 1'b0; z_dma_addr = '0; z_dma_wdata = '0;
    fork
      mem_model();
      cpu_agent();
      dma_agent();
      monitor();
    join_none
    test_reset();
    test_basic_read();
    test_tie();
    test_dma_burst();
    test_dma_last_early();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
